// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DMISS   = 2'b01,
        ST_IMISS   = 2'b10,
        ST_RECOVER = 2'b11
    } miss_st_t;
    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_W      = 2'b01;
    localparam logic [1:0] FWD_M      = 2'b10;
    localparam logic [2:0] NOREGWRITE = 3'd0;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: E-stage operand bypass select; the younger M result wins over W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic [2:0] i_rw_m,
    input  logic [2:0] i_rw_w,
    output logic [1:0] o_fwd
);
    always_comb begin
        o_fwd = (i_rw_m != NOREGWRITE && i_rd_m != 5'd0 && i_rd_m == i_rs) ? FWD_M
              : (i_rw_w != NOREGWRITE && i_rd_w != 5'd0 && i_rd_w == i_rs) ? FWD_W
              : FWD_RF;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage core with a miss FSM and watchdog.
// Define HAZARD_PERF_CNT_EN to add the StallCycCnt/FlushCnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RST_FLUSH_CYCLES = 2,
    parameter int MISS_TIMEOUT     = 1023
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W            = 32
`endif
)
(
    input  logic       CPU_CLK,
    input  logic       CPU_RST,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [1:0] RegReadD,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       MemToRegE,
    input  logic [2:0] RegWriteM,
    input  logic [2:0] RegWriteW,
    input  logic       BranchTakenE,
    input  logic       JalrE,
    input  logic       JalD,
    input  logic       IMissReq,
    input  logic       DMissReq,
    output logic       StallF,
    output logic       FlushF,
    output logic       StallD,
    output logic       FlushD,
    output logic       StallE,
    output logic       FlushE,
    output logic       StallM,
    output logic       FlushM,
    output logic       StallW,
    output logic       FlushW,
    output logic [1:0] Forward1E,
    output logic [1:0] Forward2E,
    output logic       MissTimeout,
    output logic [1:0] MissState
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);
    localparam logic [9:0] TO_MAX = 10'(MISS_TIMEOUT);
    localparam logic [9:0] TO_PRE = 10'(MISS_TIMEOUT - 1);

    miss_st_t   r_state;
    miss_st_t   w_mode;
    logic [3:0] r_rst_cnt;
    logic [9:0] r_miss_cnt;
    logic       r_timeout;
    logic       w_win;
    logic       w_run;
    logic       w_miss;
    logic       w_lu;
    logic       w_br;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    fwd_sel u_fwd1 (.i_rs(Rs1E), .i_rd_m(RdM), .i_rd_w(RdW), .i_rw_m(RegWriteM), .i_rw_w(RegWriteW), .o_fwd(w_fwd1));
    fwd_sel u_fwd2 (.i_rs(Rs2E), .i_rd_m(RdM), .i_rd_w(RdW), .i_rw_m(RegWriteM), .i_rw_w(RegWriteW), .o_fwd(w_fwd2));

    // Output mode follows the live request so the first miss cycle already stalls.
    always_comb begin
        w_win  = r_rst_cnt != 4'd0;
        w_mode = (w_win || r_state == ST_RECOVER) ? ST_RUN
               : DMissReq ? ST_DMISS
               : (IMissReq && r_state != ST_DMISS) ? ST_IMISS
               : ST_RUN;
        w_run  = !w_win && w_mode == ST_RUN;
        w_miss = w_mode == ST_DMISS || w_mode == ST_IMISS;
        w_br   = BranchTakenE || JalrE;
        w_lu   = MemToRegE && RdE != 5'd0 &&
                 ((RegReadD[1] && RdE == Rs1D) || (RegReadD[0] && RdE == Rs2D));
    end

    // A taken branch kills the load-use stall; a held jal in D must not be flushed.
    always_comb begin
        StallF      = w_miss || (w_run && w_lu && !w_br);
        StallD      = w_mode == ST_DMISS || (w_run && w_lu && !w_br);
        StallE      = w_mode == ST_DMISS;
        StallM      = w_mode == ST_DMISS;
        StallW      = 1'b0;
        FlushF      = w_win;
        FlushD      = w_win || w_mode == ST_IMISS || (w_run && (w_br || (JalD && !w_lu)));
        FlushE      = w_win || (w_mode == ST_IMISS && w_br) || (w_run && (w_br || w_lu));
        FlushM      = w_win;
        FlushW      = w_win || w_mode == ST_DMISS;
        Forward1E   = w_win ? FWD_RF : w_fwd1;
        Forward2E   = w_win ? FWD_RF : w_fwd2;
        MissTimeout = r_timeout;
        MissState   = r_state;
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            r_state    <= ST_RUN;
            r_rst_cnt  <= 4'(RST_FLUSH_CYCLES);
            r_miss_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_win) begin
            r_rst_cnt  <= r_rst_cnt - 4'd1;
        end else begin
            r_state    <= (r_state == ST_RECOVER) ? (IMissReq ? ST_IMISS : ST_RUN)
                        : DMissReq ? ST_DMISS
                        : !IMissReq ? ST_RUN
                        : (r_state == ST_DMISS) ? ST_RECOVER : ST_IMISS;
            r_miss_cnt <= !w_miss ? '0 : (r_miss_cnt == TO_MAX) ? r_miss_cnt : r_miss_cnt + 10'd1;
            r_timeout  <= r_timeout || (w_miss && r_miss_cnt == TO_PRE);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            StallCycCnt <= '0;
            FlushCnt    <= '0;
        end else if (!w_win) begin
            StallCycCnt <= StallCycCnt + CNT_W'(StallF);
            FlushCnt    <= FlushCnt + CNT_W'(w_br && w_mode != ST_DMISS);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_hazard_ctrl;
    localparam int MT = 8;

    logic       CPU_CLK, CPU_RST;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadD;
    logic       MemToRegE, BranchTakenE, JalrE, JalD, IMissReq, DMissReq;
    logic [2:0] RegWriteM, RegWriteW;
    logic       StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
    logic [1:0] Forward1E, Forward2E, MissState;
    logic       MissTimeout;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_err = 0;
    int m_state, m_win, m_cnt;
    logic m_to;

    localparam logic [16:0] RST_VEC = 17'b0101010101_00_00_0_00;

    hazard_ctrl #(.RST_FLUSH_CYCLES(2), .MISS_TIMEOUT(MT)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemToRegE(MemToRegE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .BranchTakenE(BranchTakenE), .JalrE(JalrE),
        .JalD(JalD), .IMissReq(IMissReq), .DMissReq(DMissReq),
        .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
        .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM), .StallW(StallW), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E), .MissTimeout(MissTimeout), .MissState(MissState)
    );

    assign obs = {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW,
                  Forward1E, Forward2E, MissTimeout, MissState};

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    // Reference model: states numbered as in the spec table (0 run, 1 dmiss, 2 imiss, 3 recover).
    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM != 0 && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW != 0 && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int model_mode();
        if (m_win > 0 || m_state == 3) return 0;
        if (DMissReq) return 1;
        if (IMissReq && m_state != 1) return 2;
        return 0;
    endfunction

    function automatic logic [16:0] model_out();
        logic sf, sd, se, sm, fd, fe, fw, lu, br;
        int mode;
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0;
        if (m_win > 0) return {10'b0101010101, 4'b0000, m_to, 2'(m_state)};
        lu = MemToRegE && RdE != 0 && ((RegReadD[1] && RdE == Rs1D) || (RegReadD[0] && RdE == Rs2D));
        br = BranchTakenE || JalrE;
        mode = model_mode();
        if (mode == 1) begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
        else if (mode == 2) begin sf = 1; fd = 1; fe = br; end
        else if (br) begin fd = 1; fe = 1; end
        else if (lu) begin sf = 1; sd = 1; fe = 1; end
        else if (JalD) fd = 1;
        return {sf, 1'b0, sd, fd, se, fe, sm, 1'b0, 1'b0, fw, fwd(Rs1E), fwd(Rs2E), m_to, 2'(m_state)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_win = 2; m_cnt = 0; m_to = 0;
    endtask

    task automatic model_edge();
        int mode;
        if (CPU_RST) return;
        if (m_win > 0) begin m_win--; return; end
        mode = model_mode();
        if (mode != 0) begin
            if (m_cnt < MT) m_cnt++;
            if (m_cnt == MT) m_to = 1;
        end else m_cnt = 0;
        case (m_state)
            0, 2: m_state = DMissReq ? 1 : IMissReq ? 2 : 0;
            1:    m_state = DMissReq ? 1 : IMissReq ? 3 : 0;
            default: m_state = IMissReq ? 2 : 0;
        endcase
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_in();
        Rs1D = 0; Rs2D = 0; RegReadD = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        MemToRegE = 0; RegWriteM = 0; RegWriteW = 0; BranchTakenE = 0; JalrE = 0; JalD = 0;
        IMissReq = 0; DMissReq = 0;
    endtask

    task automatic test_reset();
        CPU_RST = 1; clear_in(); RdM = 7; Rs1E = 7; RegWriteM = 3'd2; model_reset();
        tick(); tick();
        @(negedge CPU_CLK);
        n_cmp++;
        if (obs !== RST_VEC) begin n_err++; $display("FAIL reset_state: got %b expected %b", obs, RST_VEC); end
        tick();
        clear_in(); IMissReq = 1; CPU_RST = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CPU_CLK);
            n_cmp++;
            if ({FlushF, FlushD, FlushE, FlushM, FlushW, StallF, MissState} !== 8'b11111_0_00) begin
                n_err++;
                $display("FAIL reset_window[%0d]: got %b expected 11111000", k,
                         {FlushF, FlushD, FlushE, FlushM, FlushW, StallF, MissState});
            end
            tick();
        end
        @(negedge CPU_CLK);
        n_cmp++;
        if ({FlushF, StallF, MissState} !== 4'b0_1_00) begin
            n_err++; $display("FAIL window_exit: got %b expected 0100", {FlushF, StallF, MissState});
        end
        tick();
        @(negedge CPU_CLK);
        n_cmp++;
        if (MissState !== 2'b10) begin n_err++; $display("FAIL imiss_entry: got %b expected 10", MissState); end
        IMissReq = 0;
        tick();
    endtask

    task automatic test_load_use();
        logic [3:0] exp_tab [5] = '{4'b1110, 4'b0000, 4'b0000, 4'b1110, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            clear_in(); MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
            if (i == 1) MemToRegE = 0;
            if (i == 2) begin RdE = 0; Rs1D = 0; end
            if (i == 3) begin Rs1D = 3; Rs2D = 5; RegReadD = 2'b01; end
            if (i == 4) RegReadD = 2'b01;
            @(negedge CPU_CLK);
            n_cmp++;
            if ({StallF, StallD, FlushE, FlushD} !== exp_tab[i]) begin
                n_err++; $display("FAIL load_use[%0d]: got %b expected %b", i, {StallF, StallD, FlushE, FlushD}, exp_tab[i]);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_miss_seq();
        logic       d_tab  [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [1:0] ms_tab [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
        logic       sm_tab [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic       sf_tab [7] = '{1, 1, 1, 1, 0, 0, 1};
        clear_in(); IMissReq = 1;
        for (int i = 0; i < 7; i++) begin
            DMissReq = d_tab[i];
            @(negedge CPU_CLK);
            n_cmp++;
            if ({StallF, StallM, FlushW, MissState} !== {sf_tab[i], sm_tab[i], sm_tab[i], ms_tab[i]}) begin
                n_err++;
                $display("FAIL miss_seq[%0d]: got %b expected %b", i, {StallF, StallM, FlushW, MissState},
                         {sf_tab[i], sm_tab[i], sm_tab[i], ms_tab[i]});
            end
            tick();
        end
        IMissReq = 0;
        tick();
        @(negedge CPU_CLK);
        n_cmp++;
        if ({StallF, MissState} !== 3'b0_00) begin n_err++; $display("FAIL miss_exit: got %b expected 000", {StallF, MissState}); end
    endtask

    task automatic test_ctrl();
        logic [3:0] exp_tab [7] = '{4'b0011, 4'b0011, 4'b0010, 4'b1100, 4'b1100, 4'b0011, 4'b1011};
        for (int i = 0; i < 7; i++) begin
            clear_in();
            if (i < 2) begin MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10; end
            BranchTakenE = (i != 1 && i != 2);
            JalrE = (i == 1);
            JalD = (i == 2);
            DMissReq = (i == 3 || i == 4);
            IMissReq = (i == 6);
            @(negedge CPU_CLK);
            n_cmp++;
            if ({StallF, StallD, FlushD, FlushE} !== exp_tab[i]) begin
                n_err++; $display("FAIL ctrl[%0d]: got %b expected %b", i, {StallF, StallD, FlushD, FlushE}, exp_tab[i]);
            end
            tick();
        end
        clear_in();
        tick(); tick();
    endtask

    task automatic test_forward();
        int rdm [6] = '{7, 7, 7, 7, 0, 3};
        int rdw [6] = '{7, 7, 7, 9, 0, 3};
        int rs1 [6] = '{7, 7, 0, 9, 0, 3};
        int rs2 [6] = '{7, 7, 7, 7, 0, 3};
        int rwm [6] = '{2, 0, 2, 1, 1, 0};
        int rww [6] = '{2, 2, 2, 4, 1, 0};
        logic [3:0] exp_tab [6] = '{4'b1010, 4'b0101, 4'b0010, 4'b0110, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            clear_in();
            RdM = 5'(rdm[i]); RdW = 5'(rdw[i]); Rs1E = 5'(rs1[i]); Rs2E = 5'(rs2[i]);
            RegWriteM = 3'(rwm[i]); RegWriteW = 3'(rww[i]);
            DMissReq = (i == 0);
            @(negedge CPU_CLK);
            n_cmp++;
            if ({Forward1E, Forward2E} !== exp_tab[i]) begin
                n_err++; $display("FAIL forward[%0d]: got %b expected %b", i, {Forward1E, Forward2E}, exp_tab[i]);
            end
            tick();
        end
        clear_in();
        tick();
    endtask

    task automatic test_watchdog();
        clear_in(); DMissReq = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CPU_CLK);
            n_cmp++;
            if (MissTimeout !== (k > MT)) begin
                n_err++; $display("FAIL watchdog[%0d]: got %b expected %b", k, MissTimeout, k > MT);
            end
            tick();
        end
        DMissReq = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CPU_CLK);
            n_cmp++;
            if (MissTimeout !== 1'b1) begin n_err++; $display("FAIL watchdog_sticky[%0d]: got %b expected 1", k, MissTimeout); end
            tick();
        end
        DMissReq = 1;
        tick(); tick();
        CPU_RST = 1; model_reset();
        #1;
        n_cmp++;
        if (obs !== RST_VEC) begin n_err++; $display("FAIL reset_mid_miss: got %b expected %b", obs, RST_VEC); end
        tick();
        CPU_RST = 0; clear_in();
        tick(); tick();
    endtask

    task automatic test_random();
        logic [16:0] exp_v;
        clear_in();
        for (int i = 0; i < 600; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            RegReadD = 2'($urandom_range(0, 3));
            MemToRegE = ($urandom_range(0, 1) == 1);
            RegWriteM = $urandom_range(0, 1) == 1 ? 3'd0 : 3'($urandom_range(0, 7));
            RegWriteW = $urandom_range(0, 1) == 1 ? 3'd0 : 3'($urandom_range(0, 7));
            BranchTakenE = ($urandom_range(0, 4) == 0);
            JalrE = ($urandom_range(0, 6) == 0);
            JalD = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) DMissReq = ~DMissReq;
            if ($urandom_range(0, 4) == 0) IMissReq = ~IMissReq;
            @(negedge CPU_CLK);
            exp_v = model_out();
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL random[%0d]: got %b expected %b", i, obs, exp_v); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_miss_seq();
        test_ctrl();
        test_forward();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. Sits beside the decoder and the F/D/E/M/W pipeline registers.
- Produces per-stage stall/flush and E-stage operand-forward selects.
- Serialises I-cache and D-cache miss handling through a miss FSM, with a watchdog timeout.
- Holds a post-reset bubble window.

Parameters:
- RST_FLUSH_CYCLES, 2, cycles all stages stay flushed after reset release (1..15)
- MISS_TIMEOUT, 1023, miss cycles before MissTimeout sets (10-bit counter)
- CNT_W, 32, perf counter width (optional feature only)

Ports:
- CPU_CLK  in  1  core clock
- CPU_RST  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  source regs in D
- RegReadD  in  2  [1]=rs1 used, [0]=rs2 used
- Rs1E, Rs2E, RdE, RdM, RdW  in  5  stage register ids
- MemToRegE  in  1  load in E
- RegWriteM, RegWriteW  in  3  write type, 0 = no write
- BranchTakenE  in  1  resolved taken branch in E
- JalrE  in  1  jalr in E
- JalD  in  1  jal in D
- IMissReq  in  1  I-cache level: fetch not yet complete
- DMissReq  in  1  D-cache level: access in M not yet complete
- StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each
- Forward1E, Forward2E  out  2  00 reg file, 01 W result, 10 M result
- MissTimeout  out  1  sticky watchdog flag
- MissState  out  2  FSM state for debug

Behaviour:
- Async reset: every Stall*=0, every Flush*=1, Forward*=00, MissTimeout=0, MissState=RUN, rst-counter=RST_FLUSH_CYCLES, miss counter=0.
- Reset window:
  - After CPU_RST falls, all Flush*=1 for RST_FLUSH_CYCLES rising edges, then normal operation.
  - Miss and hazard inputs are ignored in this window.
  - Reset asserted mid-miss aborts the miss immediately.
- FSM states (2-bit): RUN=00, DMISS=01, IMISS=10, RECOVER=11.
  - RUN: DMissReq -> DMISS (D has priority over I); else IMissReq -> IMISS.
  - DMISS: stay while DMissReq. On drop -> RECOVER if IMissReq, else RUN.
  - IMISS: DMissReq -> DMISS (preempts; I stays pending). On IMissReq drop -> RUN.
  - RECOVER: one cycle, outputs as RUN, then IMISS (IMissReq still high) or RUN.
  - Outputs are combinational from state plus the current-cycle request, so the first miss cycle already stalls (0-cycle latency).
- DMISS outputs:
  - StallF/D/E/M=1, FlushW=1.
  - Load-use and branch/jump flushes are suppressed; they re-evaluate after release because E/D are held.
- IMISS outputs:
  - StallF=1, FlushD=1, E/M/W advance.
  - BranchTakenE|JalrE additionally asserts FlushE; StallF stays.
- Load-use (RUN/RECOVER only):
  - Condition: MemToRegE & RdE!=0 & ((RegReadD[1] & RdE==Rs1D) | (RegReadD[0] & RdE==Rs2D)).
  - Response: StallF=StallD=1, FlushE=1.
- Control hazards (RUN/RECOVER only):
  - BranchTakenE|JalrE -> FlushD=FlushE=1, overriding the load-use stall (StallF/StallD=0).
  - JalD alone -> FlushD=1.
- Forwarding (all states):
  - Forward1E=10 if RegWriteM!=0 & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW!=0 & RdW!=0 & RdW==Rs1E.
  - Else 00. Forward2E uses Rs2E the same way. M wins over W.
- Watchdog:
  - Counter increments each DMISS/IMISS cycle and clears on return to RUN.
  - Reaching MISS_TIMEOUT sets MissTimeout, which is sticky until reset. The counter saturates.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs StallCycCnt and FlushCnt [CNT_W-1:0].
  - StallCycCnt counts cycles with StallF=1.
  - FlushCnt counts branch/jalr flush events.
  - Both reset to 0, wrap at 2^CNT_W, and do not count during the reset window.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- hazard_pkg constants: FSM encodings (RUN/DMISS/IMISS/RECOVER), forward codes FWD_RF=00, FWD_W=01, FWD_M=10, and NOREGWRITE=0.
- One sub-module, fwd_sel, instantiated twice: combinational forward select per operand.

Test Plan:
- Reset pulse, RST_FLUSH_CYCLES=2, IMissReq=1 during window -> all Flush*=1 for exactly 2 edges after release, MissState stays 00, then StallF=1 / MissState=10.
- Load in E RdE=5, D reads Rs1D=5 with RegReadD=10 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
- DMissReq high 4 cycles while IMissReq high -> states 01,01,01,01,11,10. StallM=1 and FlushW=1 for those 4 cycles; then IMISS until IMissReq drops.
- BranchTakenE=1 coincident with load-use -> FlushD=FlushE=1, StallF=StallD=0. Coincident with DMissReq -> no flush until DMISS exit.
- RdM=RdW=Rs1E=7, RegWriteM=2, RegWriteW=2 -> Forward1E=10. RegWriteM=0 -> 01. Rs1E=0 -> 00.
- MISS_TIMEOUT=8, DMissReq held 20 cycles -> MissTimeout rises at miss cycle 8 and stays 1 after DMissReq drops, until CPU_RST.
